// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Port 0 is the core data port; port 1 is the external loader/debug port.
// Grants are combinational. Read data comes back one cycle after the grant.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // requester 0
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic                  i_lock0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  // requester 1
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic                  i_lock1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  // RAM side
  output logic                  o_ram_load,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1
  } state_t;

  state_t                r_state;
  logic                  r_last;       // port granted most recently
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;

  logic                  w_hold0;
  logic                  w_hold1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any_gnt;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Lock only matters for the current owner; a non-owner's lock is ignored.
  assign w_hold0 = (r_state == ST_OWN0) && i_lock0;
  assign w_hold1 = (r_state == ST_OWN1) && i_lock1;

  // Grant decision: locked owner is exclusive, otherwise sole requester wins
  // and a tie goes to the port that was not granted last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (w_hold0) begin
      w_gnt0 = i_req0;
    end else if (w_hold1) begin
      w_gnt1 = i_req1;
    end else if (i_req0 && i_req1) begin
      w_gnt0 = r_last;
      w_gnt1 = !r_last;
    end else begin
      w_gnt0 = i_req0;
      w_gnt1 = i_req1;
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_sel_addr = w_gnt1 ? i_addr1 : i_addr0;
  assign w_sel_data = w_gnt1 ? i_wdata1 : i_wdata0;

  // Ownership FSM and last-grant pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else if (w_gnt0) begin
      r_state <= ST_OWN0;
      r_last  <= 1'b0;
    end else if (w_gnt1) begin
      r_state <= ST_OWN1;
      r_last  <= 1'b1;
    end else if (!(w_hold0 || w_hold1)) begin
      r_state <= ST_IDLE;
    end
  end

  // Remember the last granted address/data so the RAM bus stays quiet when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else if (w_any_gnt) begin
      r_ram_addr <= w_sel_addr;
      r_ram_data <= w_sel_data;
    end
  end

  assign o_ram_load = (w_gnt0 & i_we0) | (w_gnt1 & i_we1);
  assign o_ram_addr = w_any_gnt ? w_sel_addr : r_ram_addr;
  assign o_ram_data = w_any_gnt ? w_sel_data : r_ram_data;

  // Read-return pipeline: one stage per port tracks which port owns the
  // RAM data arriving next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~i_we0;
      r_rvalid1 <= w_gnt1 & ~i_we1;
    end
  end

  // Capture returned read data so it persists until the next completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_rvalid0) r_rdata0 <= i_ram_data;
      if (r_rvalid1) r_rdata1 <= i_ram_data;
    end
  end

  // RAM data is only available in the rvalid cycle itself, so that cycle
  // bypasses the capture register; afterwards the registered copy is shown.
  assign o_rdata0  = r_rvalid0 ? i_ram_data : r_rdata0;
  assign o_rdata1  = r_rvalid1 ? i_ram_data : r_rdata1;
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_gnt0    = w_gnt0;
  assign o_gnt1    = w_gnt1;

endmodule
